// File: rtl/joybus_host_channel_if.sv
// Host-side bundle for one Joybus channel: PIF RAM access, control/status and the open-drain line.
interface joybus_host_channel_if;
  logic       start;
  logic [5:0] tx_len;
  logic [5:0] rx_len;
  logic       tx_rd;
  logic [5:0] tx_idx;
  logic [7:0] tx_data;
  logic       rx_wr;
  logic [5:0] rx_idx;
  logic [7:0] rx_data;
  logic       joy_oe;
  logic       joy_in;
  logic       busy;
  logic       done;
  logic       timeout_err;
  logic [5:0] rx_count;

  modport master (
    output start, tx_len, rx_len, tx_data, joy_in,
    input  tx_rd, tx_idx, rx_wr, rx_idx, rx_data, joy_oe, busy, done, timeout_err, rx_count
  );

  modport slave (
    input  start, tx_len, rx_len, tx_data, joy_in,
    output tx_rd, tx_idx, rx_wr, rx_idx, rx_data, joy_oe, busy, done, timeout_err, rx_count
  );
endinterface

// File: rtl/joybus_host_channel.sv
// Joybus host master: serialises PIF command bytes onto the line, then decodes the device reply
// back into PIF RAM. Open-drain: only ever pulls low (joy_oe) or releases.
module joybus_host_channel #(
  parameter int CLK_PER_US = 50,
  parameter int TIMEOUT_US = 64
) (
  input  logic                  clock,
  input  logic                  reset_l,
  joybus_host_channel_if.slave  bus
);
  localparam int U    = CLK_PER_US;
  localparam int TO   = TIMEOUT_US * U;
  localparam int CELL = 4 * U;
  localparam int TMAX = (TO > CELL) ? TO : CELL;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_U_LAST    = TW'(U - 1);
  localparam logic [TW-1:0] T_3U_LAST   = TW'(3 * U - 1);
  localparam logic [TW-1:0] T_2U        = TW'(2 * U);
  localparam logic [TW-1:0] T_CELL_LAST = TW'(CELL - 1);
  localparam logic [TW-1:0] T_FETCH     = TW'(CELL - 3);
  localparam logic [TW-1:0] T_TO_LAST   = TW'(TO - 1);
  localparam logic [TW-1:0] T_TO        = TW'(TO);

  typedef enum logic [3:0] {
    IDLE, FETCH, TXLOW, TXHIGH, STOPLOW, STOPHIGH, RXWAIT, RXLOW, RXSTOP, DONE
  } state_t;

  state_t        state_q;
  logic [TW-1:0] tmr_q;
  logic [7:0]    sr_q;
  logic [2:0]    bit_q;
  logic [5:0]    tx_len_q, rx_len_q;
  logic          stop_seen_q;
  logic [1:0]    sync_q;
  logic          line_p_q;

  logic          tx_rd_q, rx_wr_q, joy_oe_q, busy_q, done_q, timeout_err_q;
  logic [5:0]    tx_idx_q, rx_idx_q, rx_count_q;
  logic [7:0]    rx_data_q;

  // Synchronised line and edges; idle line is high, so the chain resets to 1.
  logic          line_s, fall, rise, rx_bit;
  logic [TW-1:0] tmr_inc, low_last;
  logic [7:0]    rx_byte;
  assign line_s   = sync_q[1];
  assign fall     = line_p_q & ~line_s;
  assign rise     = ~line_p_q & line_s;
  assign tmr_inc  = tmr_q + TW'(1);
  assign low_last = sr_q[7] ? T_U_LAST : T_3U_LAST;
  assign rx_bit   = (tmr_q < T_2U);
  assign rx_byte  = {sr_q[6:0], rx_bit};

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sync_q   <= 2'b11;
      line_p_q <= 1'b1;
    end else begin
      sync_q   <= {sync_q[0], bus.joy_in};
      line_p_q <= sync_q[1];
    end
  end

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= IDLE;
      tmr_q         <= '0;
      sr_q          <= '0;
      bit_q         <= '0;
      tx_len_q      <= '0;
      rx_len_q      <= '0;
      stop_seen_q   <= 1'b0;
      tx_rd_q       <= 1'b0;
      rx_wr_q       <= 1'b0;
      joy_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      tx_idx_q      <= '0;
      rx_idx_q      <= '0;
      rx_count_q    <= '0;
      rx_data_q     <= '0;
    end else begin
      tx_rd_q <= 1'b0;
      rx_wr_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (bus.start && !done_q) begin
          tx_len_q      <= bus.tx_len;
          rx_len_q      <= bus.rx_len;
          rx_count_q    <= '0;
          timeout_err_q <= 1'b0;
          tx_idx_q      <= '0;
          busy_q        <= 1'b1;
          if (bus.tx_len == 6'd0) state_q <= DONE;
          else begin
            // Start the first fetch at the tail of a virtual cell so the path matches later bytes.
            state_q <= FETCH;
            tx_rd_q <= 1'b1;
            tmr_q   <= TW'(CELL - 2);
          end
        end
        FETCH: begin
          tmr_q <= tmr_inc;
          if (tmr_q == T_CELL_LAST) begin
            sr_q     <= bus.tx_data;
            bit_q    <= '0;
            tx_idx_q <= tx_idx_q + 6'd1;
            tmr_q    <= '0;
            joy_oe_q <= 1'b1;
            state_q  <= TXLOW;
          end
        end
        TXLOW: begin
          tmr_q <= tmr_inc;
          if (tmr_q == low_last) begin
            joy_oe_q <= 1'b0;
            state_q  <= TXHIGH;
          end
        end
        TXHIGH: begin
          tmr_q <= tmr_inc;
          if (bit_q == 3'd7 && tx_idx_q != tx_len_q && tmr_q == T_FETCH) begin
            state_q <= FETCH;
            tx_rd_q <= 1'b1;
          end else if (tmr_q == T_CELL_LAST) begin
            tmr_q    <= '0;
            joy_oe_q <= 1'b1;
            if (bit_q == 3'd7) state_q <= STOPLOW;
            else begin
              sr_q    <= {sr_q[6:0], 1'b0};
              bit_q   <= bit_q + 3'd1;
              state_q <= TXLOW;
            end
          end
        end
        STOPLOW: begin
          tmr_q <= tmr_inc;
          if (tmr_q == T_U_LAST) begin
            joy_oe_q <= 1'b0;
            state_q  <= STOPHIGH;
          end
        end
        STOPHIGH: begin
          tmr_q <= tmr_inc;
          if (tmr_q == T_3U_LAST) begin
            bit_q   <= '0;
            tmr_q   <= TW'(1);
            state_q <= (rx_len_q == 6'd0) ? DONE : RXWAIT;
          end
        end
        RXWAIT: begin
          tmr_q <= tmr_inc;
          if (fall) begin
            tmr_q   <= TW'(1);
            state_q <= RXLOW;
          end else if (tmr_q == T_TO_LAST) begin
            timeout_err_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        RXLOW: begin
          tmr_q <= tmr_inc;
          if (rise) begin
            sr_q        <= rx_byte;
            bit_q       <= bit_q + 3'd1;
            tmr_q       <= TW'(1);
            stop_seen_q <= 1'b0;
            state_q     <= RXWAIT;
            if (bit_q == 3'd7) begin
              rx_wr_q    <= 1'b1;
              rx_data_q  <= rx_byte;
              rx_idx_q   <= rx_count_q;
              rx_count_q <= rx_count_q + 6'd1;
              if (rx_count_q + 6'd1 == rx_len_q) state_q <= RXSTOP;
            end
          end else if (tmr_q == T_TO) begin
            timeout_err_q <= 1'b1;
            state_q       <= DONE;
          end
        end
        RXSTOP: begin
          tmr_q <= tmr_inc;
          // The device stop bit is optional: its absence just runs the timer out.
          if (!stop_seen_q) begin
            if (fall) begin
              stop_seen_q <= 1'b1;
              tmr_q       <= TW'(1);
            end else if (tmr_q == T_TO_LAST) state_q <= DONE;
          end else if (rise || tmr_q == T_TO) state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_rd       = tx_rd_q;
  assign bus.tx_idx      = tx_idx_q;
  assign bus.rx_wr       = rx_wr_q;
  assign bus.rx_idx      = rx_idx_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.joy_oe      = joy_oe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.rx_count    = rx_count_q;
endmodule

// File: tb/tb_joybus_host_channel.sv
// Bench for joybus_host_channel: table of transactions against a device model, plus reset,
// zero-length, busy-start and waveform sequences.
module tb_joybus_host_channel;
  localparam int U  = 50;
  localparam int TO = 64 * U;

  logic clock = 1'b0;
  logic reset_l = 1'b0;
  logic dev_oe = 1'b0;
  int   n_tests = 0, n_fail = 0, cyc = 0;

  joybus_host_channel_if bus ();
  joybus_host_channel #(.CLK_PER_US(U), .TIMEOUT_US(64)) dut (
    .clock(clock), .reset_l(reset_l), .bus(bus.slave));

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  // Open-drain line with pull-up; RAM with one-cycle read latency.
  assign bus.joy_in = !(bus.joy_oe || dev_oe);
  logic [7:0] cmd_mem [0:63];
  always @(posedge clock) if (bus.tx_rd) bus.tx_data <= cmd_mem[bus.tx_idx];

  typedef struct packed { logic [5:0] idx; logic [7:0] data; } rxexp_t;
  rxexp_t sb_q[$];
  int lo_q[$], hi_q[$];
  int lo_len = 0, gap_len = -1, done_cnt = 0, done_cyc = 0, rel_cyc = 0;
  logic oe_prev = 1'b0;
  logic last_to;
  logic [5:0] last_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Output monitor: done capture, rx_wr scoreboard, and line pulse measurement.
  always @(negedge clock) begin
    if (bus.done) begin
      done_cnt++; last_to = bus.timeout_err; last_cnt = bus.rx_count; done_cyc = cyc;
    end
    if (bus.rx_wr) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rx_wr unexpected: idx %0d data %02h, nothing pending", bus.rx_idx, bus.rx_data);
      end else begin
        rxexp_t e;
        e = sb_q.pop_front();
        if ({bus.rx_idx, bus.rx_data} !== e) begin
          n_fail++;
          $display("FAIL rx_wr: got idx %0d data %02h want idx %0d data %02h",
                   bus.rx_idx, bus.rx_data, e.idx, e.data);
        end
      end
    end
    if (bus.joy_oe) begin
      if (!oe_prev && gap_len >= 0) hi_q.push_back(gap_len);
      lo_len  = oe_prev ? lo_len + 1 : 1;
      gap_len = -1;
    end else begin
      if (oe_prev) begin lo_q.push_back(lo_len); rel_cyc = cyc; gap_len = 1; end
      else if (gap_len >= 0) gap_len++;
      if (!bus.busy) gap_len = -1;
    end
    oe_prev = bus.joy_oe;
  end

  function automatic logic [7:0] dec_byte(input int base);
    logic [7:0] b = 8'hxx;
    if (lo_q.size() >= base + 8)
      for (int j = 0; j < 8; j++) b = {b[6:0], (lo_q[base + j] < 2 * U)};
    return b;
  endfunction

  task automatic dev_bit(input logic b);
    dev_oe = 1'b1;
    repeat (b ? U : 3 * U) @(negedge clock);
    dev_oe = 1'b0;
    repeat (b ? 3 * U : U) @(negedge clock);
  endtask

  task automatic wait_done(input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin @(negedge clock); k++; end
  endtask

  typedef struct {
    logic [5:0] tx_len, rx_len;
    logic [7:0] cmd0, cmd1;
    logic [31:0] reply;
    int dev_bytes, dev_bits;
    bit dev_stop, exp_to;
    int exp_cnt;
  } vec_t;

  task automatic run_vec(input vec_t v, input string tag);
    int d0, npulse, k;
    logic [7:0] b;
    cmd_mem[0] = v.cmd0; cmd_mem[1] = v.cmd1;
    lo_q.delete(); hi_q.delete();
    d0 = done_cnt;
    @(negedge clock);
    bus.tx_len = v.tx_len; bus.rx_len = v.rx_len; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    npulse = 8 * int'(v.tx_len) + 1;
    k = 0;
    while (lo_q.size() < npulse && k < 20000) begin @(negedge clock); k++; end
    check({tag, " tx pulses"}, lo_q.size(), npulse);
    repeat (140) @(negedge clock);
    for (int i = 0; i < v.dev_bytes; i++) begin
      b = v.reply[31 - 8 * i -: 8];
      sb_q.push_back({6'(i), b});
      for (int j = 7; j >= 0; j--) dev_bit(b[j]);
    end
    if (v.dev_bits > 0) begin
      b = v.reply[31 - 8 * v.dev_bytes -: 8];
      for (int j = 0; j < v.dev_bits; j++) dev_bit(b[7 - j]);
    end
    if (v.dev_stop) begin
      dev_oe = 1'b1; repeat (U) @(negedge clock); dev_oe = 1'b0;
    end
    wait_done(d0, 8000);
    check({tag, " done count"}, done_cnt - d0, 1);
    check({tag, " timeout_err"}, last_to, v.exp_to);
    check({tag, " rx_count"}, last_cnt, v.exp_cnt);
    check({tag, " rx pending"}, sb_q.size(), 0);
    check({tag, " tx byte0"}, dec_byte(0), v.cmd0);
    if (v.tx_len > 1) check({tag, " tx byte1"}, dec_byte(8), v.cmd1);
    check({tag, " stop low"}, lo_q.size() == npulse ? lo_q[npulse - 1] : -1, U);
    if (v.rx_len == 0) check({tag, " done after stop"}, done_cyc - rel_cyc, 3 * U - U + 1);
    else if (v.dev_bytes == 0 && v.dev_bits == 0)
      check({tag, " timeout latency"}, done_cyc - rel_cyc, 2 * U + TO);
    sb_q.delete();
    repeat (20) @(negedge clock);
  endtask

  vec_t vecs[6];

  initial begin
    int d0, k;
    vec_t v;
    vecs[0] = '{6'd1, 6'd3, 8'h00, 8'h00, 32'h05000100, 3, 0, 1'b1, 1'b0, 3};
    vecs[1] = '{6'd1, 6'd4, 8'hFF, 8'h00, 32'h00000000, 0, 0, 1'b0, 1'b1, 0};
    vecs[2] = '{6'd1, 6'd4, 8'h01, 8'h00, 32'h1234A000, 2, 3, 1'b0, 1'b1, 2};
    vecs[3] = '{6'd2, 6'd1, 8'h5A, 8'h81, 32'hA5000000, 1, 0, 1'b1, 1'b0, 1};
    vecs[4] = '{6'd1, 6'd0, 8'h3C, 8'h00, 32'h00000000, 0, 0, 1'b0, 1'b0, 0};
    vecs[5] = '{6'd1, 6'd2, 8'h02, 8'h00, 32'hFF7E0000, 2, 0, 1'b0, 1'b0, 2};

    bus.start = 1'b0; bus.tx_len = '0; bus.rx_len = '0;
    repeat (3) @(negedge clock);
    check("reset outputs", {bus.tx_rd, bus.tx_idx, bus.rx_wr, bus.rx_idx, bus.rx_data, bus.joy_oe,
                            bus.busy, bus.done, bus.timeout_err, bus.rx_count}, 0);
    reset_l = 1'b1;
    repeat (5) @(negedge clock);
    check("idle outputs", {bus.tx_rd, bus.rx_wr, bus.joy_oe, bus.busy, bus.done}, 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Exact cell timing for 0x01.
    v = '{6'd1, 6'd0, 8'h01, 8'h00, 32'h0, 0, 0, 1'b0, 1'b0, 0};
    run_vec(v, "wave");
    check("wave lows", lo_q.size(), 9);
    check("wave highs", hi_q.size(), 8);
    for (int i = 0; i < 9 && i < lo_q.size(); i++) check($sformatf("wave low%0d", i), lo_q[i], (i == 7 || i == 8) ? U : 3 * U);
    for (int i = 0; i < 8 && i < hi_q.size(); i++) check($sformatf("wave high%0d", i), hi_q[i], (i == 7) ? 3 * U : U);

    // Zero-length command, with a start landing on the done cycle.
    lo_q.delete(); d0 = done_cnt;
    @(negedge clock); bus.tx_len = 6'd0; bus.rx_len = 6'd0; bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    check("len0 busy c1", {bus.busy, bus.done}, 2'b10);
    @(negedge clock);
    check("len0 done c2", {bus.busy, bus.done}, 2'b01);
    bus.tx_len = 6'd1; bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    check("start on done ignored", {bus.busy, bus.done}, 2'b00);
    repeat (300) @(negedge clock);
    check("len0 no line", lo_q.size(), 0);
    check("len0 done count", done_cnt - d0, 1);

    // Second start while busy must not disturb the first transaction.
    cmd_mem[0] = 8'hC3; lo_q.delete(); d0 = done_cnt;
    @(negedge clock); bus.tx_len = 6'd1; bus.rx_len = 6'd0; bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    repeat (10) @(negedge clock);
    bus.tx_len = 6'd2; bus.rx_len = 6'd2; bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    wait_done(d0, 4000);
    repeat (300) @(negedge clock);
    check("busy start pulses", lo_q.size(), 9);
    check("busy start byte", dec_byte(0), 8'hC3);
    check("busy start dones", done_cnt - d0, 1);
    check("busy start status", {last_to, last_cnt}, 0);

    // Asynchronous reset in the middle of a low phase.
    cmd_mem[0] = 8'h00; d0 = done_cnt;
    @(negedge clock); bus.tx_len = 6'd1; bus.rx_len = 6'd0; bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    k = 0;
    while (!bus.joy_oe && k < 100) begin @(negedge clock); k++; end
    check("pre-reset oe", bus.joy_oe, 1);
    repeat (20) @(negedge clock);
    reset_l = 1'b0;
    #1;
    check("reset oe/busy", {bus.joy_oe, bus.busy}, 2'b00);
    repeat (5) @(negedge clock);
    reset_l = 1'b1;
    repeat (2000) @(negedge clock);
    check("reset no done", done_cnt - d0, 0);
    run_vec(vecs[0], "post-reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
